// File: rtl/rot_arbiter.sv
// Round-robin arbiter sharing one barrel rotator across NREQ requesters, 2-stage pipeline.
// Optional op_cnt handshake counter when ROT_ARB_CNT_EN is defined.

module rot_arbiter_rot #(
   parameter int N      = 256,
   parameter int LOG2_N = 8
) (
   input  logic [N-1:0]      data_i,
   input  logic [LOG2_N-1:0] k_i,
   output logic [N-1:0]      data_o
);

   logic [N-1:0] stage [LOG2_N+1];

   assign stage[0] = data_i;

   // Element 0 of the operand is the vector MSB, so "toward higher index" is a right rotate.
   for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
      localparam int SH = 1 << s;
      assign stage[s+1] = k_i[s] ? {stage[s][SH-1:0], stage[s][N-1:SH]} : stage[s];
   end

   assign data_o = stage[LOG2_N];

endmodule

module rot_arbiter #(
   parameter int N      = 256,
   parameter int LOG2_N = 8,
   parameter int NREQ   = 4,
   parameter int ID_W   = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*N-1:0]        req_bits,
   input  logic [NREQ*LOG2_N-1:0]   req_k,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_bits,
   output logic [ID_W-1:0]          out_id
`ifdef ROT_ARB_CNT_EN
   ,
   output logic [15:0]              op_cnt
`endif
);

   localparam int PTR_W = $clog2(NREQ);
   localparam int IW    = PTR_W + 1;

   logic                s1_v_q, s1_v_d;
   logic [N-1:0]        s1_bits_q, s1_bits_d;
   logic [LOG2_N-1:0]   s1_k_q, s1_k_d;
   logic [ID_W-1:0]     s1_id_q, s1_id_d;
   logic                s2_v_q, s2_v_d;
   logic [N-1:0]        s2_bits_q, s2_bits_d;
   logic [ID_W-1:0]     s2_id_q, s2_id_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

   logic [PTR_W-1:0]    grant;
   logic                grant_found;
   logic [IW-1:0]       idx_w;
   logic [PTR_W-1:0]    idx;
   logic [N-1:0]        sel_bits;
   logic [LOG2_N-1:0]   sel_k;
   logic [N-1:0]        rot_out;
   logic                s2_adv;
   logic                s1_free;
   logic                accept;

   assign s2_adv  = s1_v_q & (~s2_v_q | out_ready);
   assign s1_free = ~s1_v_q | s2_adv;
   assign accept  = grant_found & s1_free & ~rst;

   // Search starts at rr_ptr and wraps at NREQ, which need not be a power of two.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      idx_w       = '0;
      idx         = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx_w = {1'b0, rr_ptr_q} + IW'(i);
         if (idx_w >= IW'(NREQ)) begin
            idx_w = idx_w - IW'(NREQ);
         end
         idx = idx_w[PTR_W-1:0];
         if (!grant_found && req_valid[idx]) begin
            grant       = idx;
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_bits = '0;
      sel_k    = '0;
      for (int unsigned r = 0; r < NREQ; r++) begin
         if (grant == PTR_W'(r)) begin
            sel_bits = req_bits[r*N +: N];
            sel_k    = req_k[r*LOG2_N +: LOG2_N];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[grant] = 1'b1;
      end
   end

   rot_arbiter_rot #(
      .N      (N),
      .LOG2_N (LOG2_N)
   ) u_rot (
      .data_i (s1_bits_q),
      .k_i    (s1_k_q),
      .data_o (rot_out)
   );

   always_comb begin
      s1_v_d    = s1_v_q;
      s1_bits_d = s1_bits_q;
      s1_k_d    = s1_k_q;
      s1_id_d   = s1_id_q;
      rr_ptr_d  = rr_ptr_q;
      s2_v_d    = s2_v_q;
      s2_bits_d = s2_bits_q;
      s2_id_d   = s2_id_q;

      if (accept) begin
         s1_v_d    = 1'b1;
         s1_bits_d = sel_bits;
         s1_k_d    = sel_k;
         s1_id_d   = ID_W'(grant);
         rr_ptr_d  = (grant == PTR_W'(NREQ - 1)) ? '0 : grant + 1'b1;
      end else if (s2_adv) begin
         s1_v_d = 1'b0;
      end

      if (s2_adv) begin
         s2_v_d    = 1'b1;
         s2_bits_d = rot_out;
         s2_id_d   = s1_id_q;
      end else if (out_ready && s2_v_q) begin
         s2_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s1_bits_q <= '0;
         s1_k_q    <= '0;
         s1_id_q   <= '0;
         s2_v_q    <= 1'b0;
         s2_bits_q <= '0;
         s2_id_q   <= '0;
         rr_ptr_q  <= '0;
      end else begin
         s1_v_q    <= s1_v_d;
         s1_bits_q <= s1_bits_d;
         s1_k_q    <= s1_k_d;
         s1_id_q   <= s1_id_d;
         s2_v_q    <= s2_v_d;
         s2_bits_q <= s2_bits_d;
         s2_id_q   <= s2_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   assign out_valid = s2_v_q;
   assign out_bits  = s2_bits_q;
   assign out_id    = s2_id_q;

`ifdef ROT_ARB_CNT_EN
   logic [15:0] op_cnt_q, op_cnt_d;

   always_comb begin
      op_cnt_d = op_cnt_q;
      if (s2_v_q && out_ready) begin
         op_cnt_d = op_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_cnt_q <= '0;
      end else begin
         op_cnt_q <= op_cnt_d;
      end
   end

   assign op_cnt = op_cnt_q;
`endif

endmodule

// File: tb/tb_rot_arbiter.sv
// Scoreboard bench for rot_arbiter (N=8, LOG2_N=3, NREQ=4); covers op_cnt when ROT_ARB_CNT_EN is defined.

module tb_rot_arbiter;

   localparam int N      = 8;
   localparam int LOG2_N = 3;
   localparam int NREQ   = 4;
   localparam int ID_W   = 2;

   typedef struct packed {
      logic [N-1:0]    bits;
      logic [ID_W-1:0] id;
   } exp_t;

   logic                   clk;
   logic                   rst;
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*N-1:0]      req_bits;
   logic [NREQ*LOG2_N-1:0] req_k;
   logic                   out_valid;
   logic                   out_ready;
   logic [N-1:0]           out_bits;
   logic [ID_W-1:0]        out_id;
`ifdef ROT_ARB_CNT_EN
   logic [15:0]            op_cnt;
`endif

   int   checks = 0;
   int   errors = 0;
   int   acc_cnt = 0;
   exp_t exp_q[$];

   logic [N-1:0]      ops_b [3];
   logic [LOG2_N-1:0] ops_k [3];
   logic [N-1:0]      ops_e [3];

   rot_arbiter #(
      .N      (N),
      .LOG2_N (LOG2_N),
      .NREQ   (NREQ),
      .ID_W   (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_bits  (req_bits),
      .req_k     (req_k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bits  (out_bits),
      .out_id    (out_id)
`ifdef ROT_ARB_CNT_EN
      ,
      .op_cnt    (op_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #950_000;
      $display("FAIL watchdog: time limit reached, pending=%0d required 0", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: every output handshake pops the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got id=%0d bits=%b required no output", out_id, out_bits);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", {22'd0, out_id, out_bits}, {22'd0, e.id, e.bits});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
         chk("ready_without_valid", 32'(req_ready & ~req_valid), 32'd0);
         acc_cnt += $countones(req_valid & req_ready);
      end
   end

   task automatic set_op(input int r, input logic [N-1:0] b, input logic [LOG2_N-1:0] k);
      req_bits[r*N +: N]          = b;
      req_k[r*LOG2_N +: LOG2_N]   = k;
   endtask

   task automatic push_exp(input int r, input logic [N-1:0] b);
      exp_t e;
      e.bits = b;
      e.id   = ID_W'(r);
      exp_q.push_back(e);
   endtask

   task automatic issue(input int r, input logic [N-1:0] b, input logic [LOG2_N-1:0] k,
                        input logic [N-1:0] exp_b);
      int w;
      bit ok;
      w  = 0;
      ok = 1'b0;
      set_op(r, b, k);
      req_valid[r] = 1'b1;
      while (!ok && w < 20) begin
         @(negedge clk);
         if (req_ready[r]) ok = 1'b1;
         else w++;
      end
      chk("issue_granted", 32'(ok), 32'd1);
      if (ok) push_exp(r, exp_b);
      @(posedge clk);
      #1;
      req_valid[r] = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((exp_q.size() != 0 || out_valid) && w < 30) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // Requester 1 streams ops_* while out_ready is held low by the caller.
   task automatic stall_stream(input int cycles, output int acc);
      int  j;
      bit  took;
      j   = 0;
      acc = 0;
      set_op(1, ops_b[0], ops_k[0]);
      req_valid[1] = 1'b1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         took = req_ready[1];
         if (took) begin
            push_exp(1, ops_e[j]);
            acc++;
         end
         if (c >= 2) begin
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_bits", 32'(out_bits), 32'(ops_e[0]));
            chk("stall_id", 32'(out_id), 32'd1);
         end
         @(posedge clk);
         #1;
         if (took && j < 2) begin
            j++;
            set_op(1, ops_b[j], ops_k[j]);
         end
      end
   endtask

   initial begin
      int acc;
      int base;
      int cyc;

      ops_b[0] = 8'b1000_0000; ops_k[0] = 3'b011; ops_e[0] = 8'b0001_0000;
      ops_b[1] = 8'b0000_0001; ops_k[1] = 3'b011; ops_e[1] = 8'b0010_0000;
      ops_b[2] = 8'b0110_0000; ops_k[2] = 3'b011; ops_e[2] = 8'b0000_1100;

      rst       = 1'b1;
      req_valid = '1;
      req_bits  = '0;
      req_k     = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd0);
      chk("reset_out_bits", 32'(out_bits), 32'd0);
      chk("reset_out_id", 32'(out_id), 32'd0);
`ifdef ROT_ARB_CNT_EN
      chk("reset_op_cnt", 32'(op_cnt), 32'd0);
`endif
      req_valid = '0;
      rst       = 1'b0;
      @(posedge clk);
      #1;

      // Single op, one-cycle latency after the accept edge.
      issue(0, 8'b1000_0000, 3'b001, 8'b0100_0000);
      @(negedge clk);
      chk("latency_not_before", 32'(out_valid), 32'd0);
      @(negedge clk);
      chk("latency_one_cycle", 32'(out_valid), 32'd1);
      drain();

      issue(2, 8'b1100_0000, 3'b100, 8'b0000_1100);
      issue(2, 8'b1100_0000, 3'b000, 8'b1100_0000);
      issue(1, 8'b1000_0000, 3'b111, 8'b0000_0001);
      issue(3, 8'b1011_0001, 3'b010, 8'b0110_1100);
      drain();

      // All four requesting for 8 cycles from rr_ptr=0.
      set_op(0, 8'b1110_0000, 3'd1);
      set_op(1, 8'b0000_0011, 3'd2);
      set_op(2, 8'b1010_1010, 3'd5);
      set_op(3, 8'b0001_0000, 3'd6);
      for (int p = 0; p < 2; p++) begin
         push_exp(0, 8'b0111_0000);
         push_exp(1, 8'b1100_0000);
         push_exp(2, 8'b0101_0101);
         push_exp(3, 8'b0100_0000);
      end
      base      = acc_cnt;
      req_valid = '1;
      repeat (8) @(posedge clk);
      #1;
      req_valid = '0;
      chk("rr_accepts", 32'(acc_cnt - base), 32'd8);
      drain();

      // Backpressure: exactly two ops fit, output held stable.
      out_ready = 1'b0;
      stall_stream(5, acc);
      chk("stall_accepted", 32'(acc), 32'd2);
      out_ready    = 1'b1;
      req_valid[1] = 1'b0;
      drain();

      // Reset with both stages full.
      out_ready = 1'b0;
      stall_stream(3, acc);
      chk("prefill_accepted", 32'(acc), 32'd2);
      #1;
      rst = 1'b1;
      exp_q.delete();
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_req_ready", 32'(req_ready), 32'd0);
      chk("async_out_bits", 32'(out_bits), 32'd0);
      set_op(1, 8'b0100_0000, 3'd2);
      set_op(2, 8'b1111_1111, 3'd0);
      req_valid = 4'b0110;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_reset_grant", 32'(req_ready), 32'b0010);
      push_exp(1, 8'b0001_0000);
      @(posedge clk);
      #1;
      req_valid = '0;
      drain();

`ifdef ROT_ARB_CNT_EN
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("cnt_after_reset", 32'(op_cnt), 32'd0);
      @(posedge clk);
      #1;
      set_op(0, 8'b1000_0000, 3'd0);
      req_valid[0] = 1'b1;
      acc = 0;
      cyc = 0;
      while (acc < 70000 && cyc < 70100) begin
         @(negedge clk);
         cyc++;
         if (req_ready[0]) begin
            push_exp(0, 8'b1000_0000);
            acc++;
         end
      end
      @(posedge clk);
      #1;
      req_valid = '0;
      chk("cnt_accepts", 32'(acc), 32'd70000);
      drain();
      chk("op_cnt_wrap", 32'(op_cnt), 32'd4464);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
